// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch stage sitting directly after the PC register. Issues one
//   synchronous instruction-memory read per cycle at the current PC, advances
//   the PC only when a fetch is issued, and buffers returned instructions
//   (tagged with their PC) in a small FIFO toward decode. A flush discards
//   the in-flight fetch and everything queued.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_pc             current PC from the PC register
//   o_pc_en          PC register load enable (advance or load redirect target)
//   i_flush          redirect; the next-PC mux presents the target this cycle
//   o_imem_req       read request to instruction memory
//   o_imem_addr      word-aligned read address
//   i_imem_rdata     read data, valid exactly one cycle after o_imem_req
//   o_dec_valid      FIFO head valid toward decode
//   i_dec_ready      decode accepts the head entry
//   o_dec_instr      head instruction
//   o_dec_pc         head PC
// -----------------------------------------------------------------------------
module if_fetch_queue #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_pc,
   output logic              o_pc_en,
   input  logic              i_flush,
   output logic              o_imem_req,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic [DATA_W-1:0] i_imem_rdata,
   output logic              o_dec_valid,
   input  logic              i_dec_ready,
   output logic [DATA_W-1:0] o_dec_instr,
   output logic [ADDR_W-1:0] o_dec_pc
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

   logic [CNT_W-1:0]  r_count;
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic              r_inflight;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_instr [DEPTH];
   logic [ADDR_W-1:0] r_pcs   [DEPTH];

   logic              w_pop;
   logic              w_write;
   logic              w_credit;
   logic              w_issue;
   logic [CNT_W:0]    w_occupancy;
   logic              w_unused_pc_lsb;

   // Word alignment discards the PC's byte offset.
   assign w_unused_pc_lsb = ^i_pc[1:0];

   assign o_dec_valid = (r_count != '0);
   assign o_dec_instr = r_instr[r_rptr];
   assign o_dec_pc    = r_pcs[r_rptr];

   assign w_pop   = o_dec_valid & i_dec_ready & ~i_flush;
   assign w_write = r_inflight & ~i_flush;

   // Slots committed after this cycle: queued entries minus the one leaving,
   // plus the response still on its way. Including the same-cycle pop (a
   // combinational path from i_dec_ready) keeps throughput at one per cycle.
   assign w_occupancy = {1'b0, r_count} - (CNT_W + 1)'(w_pop) + (CNT_W + 1)'(r_inflight);
   assign w_credit    = (w_occupancy < DEPTH_C);

   assign w_issue     = w_credit & ~i_flush;
   assign o_imem_req  = w_issue;
   assign o_imem_addr = {i_pc[ADDR_W-1:2], 2'b00};
   // On flush the PC register must load the redirect target even with no issue.
   assign o_pc_en     = w_issue | i_flush;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_inflight <= 1'b0;
         r_pc       <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_instr[i] <= '0;
            r_pcs[i]   <= '0;
         end
      end else if (i_flush) begin
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_inflight <= 1'b0;
      end else begin
         if (w_write) begin
            r_instr[r_wptr] <= i_imem_rdata;
            r_pcs[r_wptr]   <= r_pc;
            r_wptr          <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         r_count    <= r_count + CNT_W'(w_write) - CNT_W'(w_pop);
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc <= o_imem_addr;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_queue
//   Bench for if_fetch_queue. Provides the surrounding PC register and a
//   synchronous instruction memory, and keeps a queue-level model of what the
//   fetch stage must present each cycle.
// -----------------------------------------------------------------------------
module tb_if_fetch_queue;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] pc;
   logic              pc_en;
   logic              flush;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              dec_valid;
   logic              dec_ready;
   logic [DATA_W-1:0] dec_instr;
   logic [ADDR_W-1:0] dec_pc;
   logic [ADDR_W-1:0] tgt;

   int checks = 0;
   int errors = 0;

   // Model state: queued PCs toward decode, plus the one outstanding fetch.
   logic [31:0] q[$];
   bit          pend;
   logic [31:0] pend_addr;
   bit          have_last;
   logic [31:0] last_pc;

   if_fetch_queue #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_pc         (pc),
      .o_pc_en      (pc_en),
      .i_flush      (flush),
      .o_imem_req   (imem_req),
      .o_imem_addr  (imem_addr),
      .i_imem_rdata (imem_rdata),
      .o_dec_valid  (dec_valid),
      .i_dec_ready  (dec_ready),
      .o_dec_instr  (dec_instr),
      .o_dec_pc     (dec_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction contents as a function of address, so instr/pc mixups show.
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // PC register: reset value, +4 on enable, redirect target on flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= RESET_PC;
      else if (pc_en) pc <= flush ? tgt : pc + 32'd4;
   end

   // Synchronous memory; data is garbage on cycles without a request.
   always_ff @(posedge clk) begin
      imem_rdata <= imem_req ? mem_f(imem_addr) : $urandom();
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare outputs against the model, then advance the model by one clock.
   task automatic step();
      bit          exp_valid, pop, credit, exp_req;
      int          occ;
      logic [31:0] exp_addr;
      exp_valid = (q.size() != 0);
      pop       = exp_valid && dec_ready && !flush;
      occ       = q.size() - (pop ? 1 : 0) + (pend ? 1 : 0);
      credit    = (occ < int'(DEPTH));
      exp_req   = credit && !flush;
      exp_addr  = {pc[31:2], 2'b00};

      chk("dec_valid", {31'd0, dec_valid}, {31'd0, exp_valid});
      chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      chk("pc_en", {31'd0, pc_en}, {31'd0, exp_req || flush});
      chk("imem_addr", imem_addr, exp_addr);
      if (exp_valid) begin
         chk("dec_pc", dec_pc, q[0]);
         chk("dec_instr", dec_instr, mem_f(q[0]));
      end
      if (pop) begin
         if (have_last) chk("pc_seq", dec_pc, last_pc + 32'd4);
         last_pc   = dec_pc;
         have_last = 1'b1;
      end

      if (flush) begin
         q.delete();
         pend      = 1'b0;
         have_last = 1'b0;
      end else begin
         if (pop) void'(q.pop_front());
         if (pend) q.push_back(pend_addr);
         pend      = exp_req;
         pend_addr = exp_addr;
      end
   endtask

   task automatic sample(input bit r, input bit f, input logic [31:0] t);
      dec_ready = r;
      flush     = f;
      tgt       = t;
      @(negedge clk);
      step();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input bit r, input bit f, input logic [31:0] t);
      sample(r, f, t);
      advance();
   endtask

   // Asynchronous reset mid-cycle; outputs must drop before any clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'd0, dec_valid}, 32'd0);
      chk("rst_dec_pc", dec_pc, 32'd0);
      chk("rst_dec_instr", dec_instr, 32'd0);
      q.delete();
      pend      = 1'b0;
      have_last = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b1;
      dec_ready = 1'b1;
      flush     = 1'b0;
      tgt       = '0;
      pend      = 1'b0;
      pend_addr = '0;
      have_last = 1'b0;
      last_pc   = '0;
      #2;

      // Streaming from reset with decode always ready.
      do_reset();
      sample(1'b1, 1'b0, 32'h0);
      chk("t1_addr_c0", imem_addr, 32'h0040_0000);
      chk("t1_pc_en_c0", {31'd0, pc_en}, 32'd1);
      advance();
      sample(1'b1, 1'b0, 32'h0);
      chk("t1_valid_c1", {31'd0, dec_valid}, 32'd0);
      advance();
      sample(1'b1, 1'b0, 32'h0);
      chk("t1_pc_c2", dec_pc, 32'h0040_0000);
      advance();
      sample(1'b1, 1'b0, 32'h0);
      chk("t1_pc_c3", dec_pc, 32'h0040_0004);
      advance();
      sample(1'b1, 1'b0, 32'h0);
      chk("t1_pc_c4", dec_pc, 32'h0040_0008);
      chk("t1_pc_en_c4", {31'd0, pc_en}, 32'd1);
      advance();

      // Decode stalled: two fetches, then PC frozen at 0x0040_0008.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0);
      sample(1'b0, 1'b0, 32'h0);
      chk("t2_pc_en", {31'd0, pc_en}, 32'd0);
      chk("t2_pc_frozen", pc, 32'h0040_0008);
      chk("t2_head", dec_pc, 32'h0040_0000);
      advance();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0);

      // Reset with two entries queued, then flush with a response in flight.
      do_reset();
      sample(1'b0, 1'b0, 32'h0);
      chk("t5_restart_addr", imem_addr, 32'h0040_0000);
      advance();
      cyc(1'b0, 1'b0, 32'h0);
      sample(1'b0, 1'b1, 32'h0040_0100);
      chk("t3_req_on_flush", {31'd0, imem_req}, 32'd0);
      chk("t3_pc_en_on_flush", {31'd0, pc_en}, 32'd1);
      advance();
      sample(1'b1, 1'b0, 32'h0);
      chk("t3_valid_after", {31'd0, dec_valid}, 32'd0);
      chk("t3_target_addr", imem_addr, 32'h0040_0100);
      advance();
      cyc(1'b1, 1'b0, 32'h0);
      sample(1'b1, 1'b0, 32'h0);
      chk("t3_first_pc", dec_pc, 32'h0040_0100);
      advance();

      // Flush coinciding with a pop.
      cyc(1'b1, 1'b0, 32'h0);
      sample(1'b1, 1'b1, 32'h0040_0200);
      chk("t4_valid_at_flush", {31'd0, dec_valid}, 32'd1);
      advance();
      sample(1'b1, 1'b0, 32'h0);
      chk("t4_empty_after", {31'd0, dec_valid}, 32'd0);
      advance();
      cyc(1'b1, 1'b0, 32'h0);
      sample(1'b1, 1'b0, 32'h0);
      chk("t4_first_pc", dec_pc, 32'h0040_0200);
      advance();

      // Random decode backpressure with occasional redirects and resets.
      for (int i = 0; i < 3000; i++) begin
         int unsigned r;
         r = $urandom_range(0, 999);
         if (r < 4) begin
            do_reset();
         end else begin
            logic [31:0] t;
            t = $urandom();
            if (t[4]) t[1:0] = 2'b00;
            cyc(1'($urandom_range(0, 1)), r < 40, t);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
